// File: rtl/mem_interface_if.sv
// ---------------------------------------------------------------------------
// mem_interface_if
// Groups the bus-side and RAM-side signals of the memory stage.
//   slave  modport : the memory stage itself (mem_interface)
//   master modport : whatever drives it (control unit, bus mux, RAM model)
// Signals:
//   BusMuxOut[31:0]        value from the bus multiplexer
//   MARin / MDRin          register load strobes
//   Read / Write           transaction start commands
//   MDRq[31:0]             MDR contents, fed back to the bus mux
//   mem_req / mem_we       RAM request and direction (1 = write)
//   mem_addr[ADDR_W-1:0]   RAM address (= MAR)
//   mem_wdata / mem_rdata  RAM write / read data
//   mem_ack                RAM completion strobe
//   busy / done / err      status to the control unit
// ---------------------------------------------------------------------------
interface mem_interface_if #(
    parameter int ADDR_W = 9
);
    logic [31:0]       BusMuxOut;
    logic              MARin;
    logic              MDRin;
    logic              Read;
    logic              Write;
    logic [31:0]       MDRq;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  BusMuxOut, MARin, MDRin, Read, Write, mem_rdata, mem_ack,
        output MDRq, mem_req, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport master (
        output BusMuxOut, MARin, MDRin, Read, Write, mem_rdata, mem_ack,
        input  MDRq, mem_req, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/mem_interface.sv
// ---------------------------------------------------------------------------
// mem_interface
// Memory-side stage of the datapath. Holds MAR and MDR, runs a req/ack
// handshake with external RAM for read and write cycles and reports
// busy / one-cycle done / sticky timeout error to the control unit.
// Ports:
//   clock  rising-edge system clock
//   clear  asynchronous active-low reset
//   bus    mem_interface_if.slave (bus, command, RAM and status signals)
// All outputs are decoded from registers only; there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15     // 1..255 wait cycles before abort
) (
    input  logic           clock,
    input  logic           clear,
    mem_interface_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter value on the last wait cycle; no ack on that edge aborts.
    localparam logic [7:0] lastCnt = 8'(TIMEOUT - 1);

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] marReg,   marNext;
    logic [31:0]       mdrReg,   mdrNext;
    logic [7:0]        cntReg,   cntNext;
    logic              errReg,   errNext;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            stateReg <= IDLE;
            marReg   <= '0;
            mdrReg   <= '0;
            cntReg   <= '0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            marReg   <= marNext;
            mdrReg   <= mdrNext;
            cntReg   <= cntNext;
            errReg   <= errNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        marNext   = marReg;
        mdrNext   = mdrReg;
        cntNext   = cntReg;
        errNext   = errReg;

        unique case (stateReg)
            IDLE: begin
                // MAR loads even alongside a command, so the transaction
                // started on this edge already sees the new address.
                if (bus.MARin)
                    marNext = bus.BusMuxOut[ADDR_W-1:0];
                // A read will overwrite MDR, so a simultaneous MDR load is dropped.
                if (bus.MDRin && !bus.Read)
                    mdrNext = bus.BusMuxOut;
                if (bus.Read) begin
                    stateNext = RD_WAIT;
                    cntNext   = '0;
                    errNext   = 1'b0;
                end else if (bus.Write) begin
                    stateNext = WR_WAIT;
                    cntNext   = '0;
                    errNext   = 1'b0;
                end
            end

            RD_WAIT, WR_WAIT: begin
                if (bus.mem_ack) begin
                    if (stateReg == RD_WAIT)
                        mdrNext = bus.mem_rdata;
                    stateNext = DONE;
                end else if (cntReg == lastCnt) begin
                    // Abort quietly: no done pulse, MDR untouched.
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end else begin
                    cntNext = cntReg + 8'd1;
                end
            end

            DONE: stateNext = IDLE;

            default: stateNext = IDLE;
        endcase
    end

    assign bus.MDRq      = mdrReg;
    assign bus.mem_addr  = marReg;
    assign bus.mem_wdata = mdrReg;
    assign bus.mem_req   = (stateReg == RD_WAIT) || (stateReg == WR_WAIT);
    assign bus.mem_we    = (stateReg == WR_WAIT);
    assign bus.done      = (stateReg == DONE);
    assign bus.busy      = (stateReg != IDLE);
    assign bus.err       = errReg;
endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory-side stage that consumes BusMuxOut and feeds the MDR bus source back into the bus multiplexer.
- Holds MAR and MDR.
- Runs a req/ack handshake with external RAM for read and write cycles.
- Reports completion (done), busy and timeout error to the control unit.

Parameters:
ADDR_W, 9, width of MAR and mem_addr
TIMEOUT, 15, max wait cycles for mem_ack before abort (1..255)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-low reset
BusMuxOut  input  32  bus value from bus multiplexer
MARin  input  1  load MAR from BusMuxOut[ADDR_W-1:0]
MDRin  input  1  load MDR from BusMuxOut
Read  input  1  start memory read into MDR
Write  input  1  start memory write of MDR
MDRq  output  32  current MDR contents (drives bus MDR input)
mem_req  output  1  memory request
mem_we  output  1  1=write, 0=read; valid while mem_req
mem_addr  output  ADDR_W  memory address (= MAR)
mem_wdata  output  32  write data (= MDR)
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  memory completion strobe, sampled at clock edge
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clock; reset clear is asynchronous and active-low.
- Reset (clear=0, async):
  - State = IDLE; MAR = 0; MDR = 0; wait counter = 0.
  - mem_req = 0, mem_we = 0, done = 0, busy = 0, err = 0.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE. All outputs are Moore/registered; no combinational path from inputs to outputs.
- mem_req = (state == RD_WAIT or WR_WAIT).
- mem_we = (state == WR_WAIT).
- done = (state == DONE).
- mem_addr = MAR and mem_wdata = MDR, both continuously.
- IDLE:
  - MARin=1: MAR <= BusMuxOut[ADDR_W-1:0].
  - MDRin=1 and Read=0: MDR <= BusMuxOut.
  - MARin and MDRin may be asserted in the same cycle; both load.
  - Read=1: go to RD_WAIT, counter <= 0, err <= 0. Read has priority; Write in the same cycle is ignored.
  - Write=1 (Read=0): go to WR_WAIT, counter <= 0, err <= 0.
  - Read/Write and MARin in the same cycle: MAR loads, and the transaction uses the new MAR value.
  - mem_ack in IDLE is ignored.
- RD_WAIT:
  - mem_ack=1: MDR <= mem_rdata, go to DONE.
  - No ack: counter increments. When counter == TIMEOUT-1 without ack, go to IDLE, err <= 1, MDR unchanged, no done pulse.
- WR_WAIT: same as RD_WAIT, except MDR is never modified.
- DONE: unconditionally go to IDLE.
- Inputs ignored while not IDLE: MARin, MDRin, Read, Write. MAR and MDR are therefore stable for the whole transaction.
- Latency:
  - Read/Write sampled at edge N; mem_req high from N+1.
  - Ack sampled at edge K; done high during cycle K+1 (mem_req already low).
  - Next command accepted at edge K+2.
  - Zero-wait memory (ack at first sampled edge): 3 cycles from command to IDLE.
- err: set only by timeout; cleared by reset or by the next accepted Read/Write.
- Reset mid-transaction: immediate abort; mem_req drops asynchronously; MAR and MDR cleared.
- Width rule: BusMuxOut bits above ADDR_W-1 are discarded on MAR load.

Test Plan:
- Reset: clear=0 with random inputs → MDRq=0, mem_addr=0, mem_req=0, busy=0, err=0. Release clear → still idle.
- Write handshake: MARin with bus=0x0000_0054 → mem_addr=0x054. MDRin with bus=0xDEAD_BEEF, then Write; ack after 3 cycles → mem_req/mem_we high exactly 3 cycles with mem_wdata=0xDEADBEEF, done single pulse, MDRq unchanged.
- Read handshake: MAR=0x054; Read; ack on 1st cycle with mem_rdata=0x1234_5678 → MDRq=0x12345678 during the done cycle. Total 3 cycles IDLE→IDLE.
- Priority and ignored inputs:
  - Read and Write together → read (mem_we=0).
  - MDRin bus=0xFFFF_FFFF during RD_WAIT → MDR not loaded.
  - MARin bus=0x1FF during WR_WAIT → mem_addr unchanged.
  - mem_ack pulsed in IDLE → no state change.
- Timeout: TIMEOUT=15, Read, no ack → mem_req high 15 cycles, then IDLE, err=1, done never pulses, MDR unchanged. Next Write clears err.
- Async reset mid-read: clear low during RD_WAIT cycle 2 → mem_req=0 before the next edge. Late ack after release is ignored.
